// File: rtl/rv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the multicycle RV32I control unit: FSM state
// encoding, base opcodes, instruction classes and the pc_src / wb_sel /
// imm_sel / alu_op encodings driven towards the datapath.
// ----------------------------------------------------------------------------
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR,
        CL_LOAD, CL_STORE, CL_BRANCH, CL_ILLEGAL
    } op_class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

endpackage

// File: rtl/ctrl_main_decoder.sv
// ----------------------------------------------------------------------------
// ctrl_main_decoder
// Purely combinational main decoder: maps the registered instruction fields
// to an instruction class plus the static datapath selects.
//   opcode_i   [6:0]  instruction opcode
//   fn3_i      [2:0]  funct3
//   fn7_5_i           funct7 bit 5 (SUB / SRA selector)
//   op_class_o        instruction class (CL_ILLEGAL for unknown opcodes)
//   alu_op_o   [3:0]  ALU operation
//   alu_src_a_o       0 rs1, 1 pc
//   alu_src_b_o       0 rs2, 1 imm
//   imm_sel_o  [2:0]  immediate format
//   legal_o           opcode is one of the nine supported classes
// Unknown opcodes drive all selects to zero.
// ----------------------------------------------------------------------------
module ctrl_main_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] fn3_i,
    input  logic       fn7_5_i,
    output op_class_e  op_class_o,
    output logic [3:0] alu_op_o,
    output logic       alu_src_a_o,
    output logic       alu_src_b_o,
    output logic [2:0] imm_sel_o,
    output logic       legal_o
);

    // NOTE: every output gets a default before the case so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        op_class_o  = CL_ILLEGAL;
        alu_op_o    = ALU_ADD;
        alu_src_a_o = 1'b0;
        alu_src_b_o = 1'b0;
        imm_sel_o   = IMM_I;
        legal_o     = 1'b1;
        unique case (opcode_i)
            OP_R: begin
                op_class_o = CL_R;
                alu_op_o   = {fn7_5_i, fn3_i};
            end
            OP_IMM: begin
                // Only the shift-right encoding uses bit 30 as SRA; for the
                // other I-type ops that bit belongs to the immediate.
                op_class_o  = CL_I;
                alu_op_o    = {fn7_5_i & (fn3_i == 3'b101), fn3_i};
                alu_src_b_o = 1'b1;
            end
            OP_LUI: begin
                op_class_o  = CL_LUI;
                alu_src_b_o = 1'b1;
                imm_sel_o   = IMM_U;
            end
            OP_AUIPC: begin
                op_class_o  = CL_AUIPC;
                alu_src_a_o = 1'b1;
                alu_src_b_o = 1'b1;
                imm_sel_o   = IMM_U;
            end
            OP_JAL: begin
                op_class_o  = CL_JAL;
                alu_src_b_o = 1'b1;
                imm_sel_o   = IMM_J;
            end
            OP_JALR: begin
                op_class_o  = CL_JALR;
                alu_src_b_o = 1'b1;
            end
            OP_LOAD: begin
                op_class_o  = CL_LOAD;
                alu_src_b_o = 1'b1;
            end
            OP_STORE: begin
                op_class_o  = CL_STORE;
                alu_src_b_o = 1'b1;
                imm_sel_o   = IMM_S;
            end
            OP_BRANCH: begin
                op_class_o = CL_BRANCH;
                alu_op_o   = ALU_SUB;
                imm_sel_o  = IMM_B;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Control FSM of a multicycle RV32I core: IDLE -> FETCH -> DECODE -> EXEC
// -> (MEM) -> (WB), with a memory-handshake timeout that traps into HALT.
//   MEM_TIMEOUT        max wait cycles on imem_ack/dmem_ack (0 = no timeout)
//   clk, rst_n         clock, asynchronous active-low reset
//   run                level enable for leaving IDLE / continuing
//   imem_req/imem_ack  fetch handshake; ir_we loads the instruction register
//   opcode/fn3/fn7     fields of the instruction register
//   br_taken           branch comparator result
//   dmem_req/dmem_we/dmem_ack  data-memory handshake
//   pc_we, pc_src      PC update strobe and source
//   reg_we, wb_sel     register write strobe and write-back source
//   alu_op, alu_src_a, alu_src_b, imm_sel   datapath selects
//   busy, err, state   status: active, sticky fault, debug state
// Macro MC_ILLEGAL_TRAP_EN: illegal opcodes trap to HALT with err=1;
// otherwise they retire as a NOP.
// ----------------------------------------------------------------------------
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       ir_we,
    input  logic [6:0] opcode,
    input  logic [2:0] fn3,
    input  logic [6:0] fn7,
    input  logic       br_taken,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [2:0] imm_sel,
    output logic       busy,
    output logic       err,
    output logic [2:0] state
);

    localparam int         CW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic       TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    op_class_e  dec_class;
    logic [3:0] dec_alu_op;
    logic       dec_src_a, dec_src_b, dec_legal;
    logic [2:0] dec_imm_sel;
    logic       sel_en;
    logic       timeout_hit;
    state_e     run_next;

    // Only bit 5 of funct7 affects control.
    logic unused_fn7;
    assign unused_fn7 = ^{fn7[6], fn7[4:0]};

    ctrl_main_decoder u_dec (
        .opcode_i    (opcode),
        .fn3_i       (fn3),
        .fn7_5_i     (fn7[5]),
        .op_class_o  (dec_class),
        .alu_op_o    (dec_alu_op),
        .alu_src_a_o (dec_src_a),
        .alu_src_b_o (dec_src_b),
        .imm_sel_o   (dec_imm_sel),
        .legal_o     (dec_legal)
    );

    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);
    assign run_next    = run ? ST_FETCH : ST_IDLE;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;        // leaving a wait state always clears the counter
        err_d    = err_q;
        sel_en   = 1'b0;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        pc_src   = PC_PLUS4;
        reg_we   = 1'b0;
        wb_sel   = WB_ALU;
        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin          // ack wins over a same-cycle timeout
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = TO_EN ? cnt_q + CW'(1) : '0;
                end
            end
            ST_DECODE: begin
                sel_en = 1'b1;
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d = ST_HALT;
                    err_d   = 1'b1;
`else
                    pc_we   = 1'b1;
                    state_d = run_next;
`endif
                end
            end
            ST_EXEC: begin
                sel_en = 1'b1;
                case (dec_class)
                    CL_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_src  = br_taken ? PC_IMM : PC_PLUS4;
                        state_d = run_next;
                    end
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    default:           state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                sel_en   = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = (dec_class == CL_STORE);
                if (dmem_ack) begin
                    if (dec_class == CL_STORE) begin
                        pc_we   = 1'b1;
                        state_d = run_next;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = TO_EN ? cnt_q + CW'(1) : '0;
                end
            end
            ST_WB: begin
                sel_en  = 1'b1;
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                state_d = run_next;
                case (dec_class)
                    CL_JAL:  pc_src = PC_IMM;
                    CL_JALR: pc_src = PC_JALR;
                    default: pc_src = PC_PLUS4;
                endcase
                case (dec_class)
                    CL_LOAD:         wb_sel = WB_MEM;
                    CL_JAL, CL_JALR: wb_sel = WB_PC4;
                    CL_LUI:          wb_sel = WB_IMM;
                    default:         wb_sel = WB_ALU;
                endcase
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoder selects are only presented while an instruction is in flight.
    assign alu_op    = sel_en ? dec_alu_op  : 4'd0;
    assign alu_src_a = sel_en & dec_src_a;
    assign alu_src_b = sel_en & dec_src_b;
    assign imm_sel   = sel_en ? dec_imm_sel : 3'd0;

    assign busy  = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign err   = err_q;
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench: a trace generator builds the expected per-cycle
// behaviour of each instruction from the instruction-level rules, the player
// drives inputs from that trace and compares every output each cycle.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int TB_TIMEOUT = 4;

    localparam int K_R = 0, K_I = 1, K_LUI = 2, K_AUIPC = 3, K_JAL = 4,
                   K_JALR = 5, K_LOAD = 6, K_STORE = 7, K_BR = 8, K_ILL = 9;

    logic       clk = 1'b0;
    logic       rst_n, run, imem_ack, dmem_ack, br_taken;
    logic [6:0] opcode, fn7;
    logic [2:0] fn3;
    logic       imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we;
    logic       alu_src_a, alu_src_b, busy, err;
    logic [1:0] pc_src, wb_sel;
    logic [3:0] alu_op;
    logic [2:0] imm_sel, state;

    multicycle_control #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
        .opcode(opcode), .fn3(fn3), .fn7(fn7), .br_taken(br_taken),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_sel(imm_sel), .busy(busy), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run, iack, dack, br;
        logic [31:0] ir;
        logic [2:0]  st;
        logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, busy, err;
        logic [1:0]  pc_src, wb_sel;
        logic [3:0]  alu_op;
        logic        src_a, src_b;
        logic [2:0]  imm_sel;
    } cyc_t;

    cyc_t        trace[$];
    logic [31:0] cur_ir = 32'h0;
    bit          start_idle;
    bit          halted;
    int          checks   = 0;
    int          failures = 0;
    int          cyc_n    = 0;
    logic [6:0]  ops [10];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int kind_of(logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BR;
            default:    return K_ILL;
        endcase
    endfunction

    // A cycle in state st with no strobes; unused inputs carry noise.
    function automatic cyc_t blank(logic [2:0] st);
        cyc_t c;
        c.run = 1'b1; c.iack = 1'($urandom); c.dack = 1'($urandom); c.br = 1'($urandom);
        c.ir = cur_ir; c.st = st;
        c.imem_req = 0; c.ir_we = 0; c.dmem_req = 0; c.dmem_we = 0;
        c.pc_we = 0; c.reg_we = 0; c.pc_src = 0; c.wb_sel = 0;
        c.alu_op = 0; c.src_a = 0; c.src_b = 0; c.imm_sel = 0;
        c.busy = (st != 3'd0) && (st != 3'd6);
        c.err = 1'b0;
        return c;
    endfunction

    function automatic cyc_t with_sel(cyc_t c, int kind, logic [31:0] ir);
        logic [2:0] f3;
        logic       b30;
        f3 = ir[14:12];
        b30 = ir[30];
        c.src_a = (kind == K_AUIPC);
        c.src_b = !(kind == K_R || kind == K_BR || kind == K_ILL);
        case (kind)
            K_R:     c.alu_op = {b30, f3};
            K_I:     c.alu_op = {b30 && (f3 == 3'b101), f3};
            K_BR:    c.alu_op = 4'b1000;
            default: c.alu_op = 4'b0000;
        endcase
        case (kind)
            K_LUI, K_AUIPC: c.imm_sel = 3'd3;
            K_JAL:          c.imm_sel = 3'd4;
            K_STORE:        c.imm_sel = 3'd1;
            K_BR:           c.imm_sel = 3'd2;
            default:        c.imm_sel = 3'd0;
        endcase
        return c;
    endfunction

    task automatic halt_tail();
        cyc_t c;
        repeat (2) begin
            c = blank(3'd6);
            c.err = 1'b1;
            trace.push_back(c);
        end
        halted = 1'b1;
    endtask

    // Expected cycle trace of one instruction: id/dd are the number of
    // cycles imem_ack/dmem_ack stay low before arriving.
    task automatic model_instr(input logic [31:0] inst, input bit br, input int id,
                               input int dd, input bit run_end);
        cyc_t c;
        int   kind;
        if (start_idle) begin
            repeat ($urandom_range(0, 2)) begin
                c = blank(3'd0); c.run = 1'b0; trace.push_back(c);
            end
            c = blank(3'd0); trace.push_back(c);
        end
        for (int k = 0; k <= id; k++) begin
            c = blank(3'd1);
            c.imem_req = 1'b1;
            c.iack = (k == id);
            c.ir_we = (k == id);
            trace.push_back(c);
            if (k != id && TB_TIMEOUT > 0 && k == TB_TIMEOUT - 1) begin
                halt_tail();
                return;
            end
        end
        cur_ir = inst;
        kind = kind_of(inst[6:0]);
        c = with_sel(blank(3'd2), kind, inst);
        if (kind == K_ILL) begin
`ifdef MC_ILLEGAL_TRAP_EN
            trace.push_back(c);
            halt_tail();
`else
            c.pc_we = 1'b1; c.run = run_end;
            trace.push_back(c);
            start_idle = !run_end;
`endif
            return;
        end
        trace.push_back(c);
        c = with_sel(blank(3'd3), kind, inst);
        if (kind == K_BR) begin
            c.br = br; c.pc_we = 1'b1; c.pc_src = br ? 2'd1 : 2'd0; c.run = run_end;
            trace.push_back(c);
            start_idle = !run_end;
            return;
        end
        trace.push_back(c);
        if (kind == K_LOAD || kind == K_STORE) begin
            for (int k = 0; k <= dd; k++) begin
                c = with_sel(blank(3'd4), kind, inst);
                c.dmem_req = 1'b1;
                c.dmem_we = (kind == K_STORE);
                c.dack = (k == dd);
                if (k == dd && kind == K_STORE) begin
                    c.pc_we = 1'b1; c.run = run_end;
                    trace.push_back(c);
                    start_idle = !run_end;
                    return;
                end
                trace.push_back(c);
                if (k != dd && TB_TIMEOUT > 0 && k == TB_TIMEOUT - 1) begin
                    halt_tail();
                    return;
                end
            end
        end
        c = with_sel(blank(3'd5), kind, inst);
        c.reg_we = 1'b1; c.pc_we = 1'b1; c.run = run_end;
        c.pc_src = (kind == K_JAL) ? 2'd1 : (kind == K_JALR) ? 2'd2 : 2'd0;
        c.wb_sel = (kind == K_LOAD) ? 2'd1 : (kind == K_JAL || kind == K_JALR) ? 2'd2 :
                   (kind == K_LUI) ? 2'd3 : 2'd0;
        trace.push_back(c);
        start_idle = !run_end;
    endtask

    task automatic cmp(input cyc_t c);
        string s;
        s = $sformatf("@%0d", cyc_n);
        check({"state", s},     state,     c.st);
        check({"imem_req", s},  imem_req,  c.imem_req);
        check({"ir_we", s},     ir_we,     c.ir_we);
        check({"dmem_req", s},  dmem_req,  c.dmem_req);
        check({"dmem_we", s},   dmem_we,   c.dmem_we);
        check({"pc_we", s},     pc_we,     c.pc_we);
        check({"pc_src", s},    pc_src,    c.pc_src);
        check({"reg_we", s},    reg_we,    c.reg_we);
        check({"wb_sel", s},    wb_sel,    c.wb_sel);
        check({"alu_op", s},    alu_op,    c.alu_op);
        check({"alu_src_a", s}, alu_src_a, c.src_a);
        check({"alu_src_b", s}, alu_src_b, c.src_b);
        check({"imm_sel", s},   imm_sel,   c.imm_sel);
        check({"busy", s},      busy,      c.busy);
        check({"err", s},       err,       c.err);
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic play(input int n);
        cyc_t c;
        for (int i = 0; i < n && trace.size() > 0; i++) begin
            c = trace.pop_front();
            run = c.run; imem_ack = c.iack; dmem_ack = c.dack; br_taken = c.br;
            opcode = c.ir[6:0]; fn3 = c.ir[14:12]; fn7 = c.ir[31:25];
            @(negedge clk);
            cmp(c);
            @(posedge clk);
            #1;
            cyc_n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_state",    state,    3'd0);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_pc_we",    pc_we,    1'b0);
        check("rst_reg_we",   reg_we,   1'b0);
        check("rst_ir_we",    ir_we,    1'b0);
        check("rst_alu_op",   alu_op,   4'd0);
        check("rst_imm_sel",  imm_sel,  3'd0);
        check("rst_err",      err,      1'b0);
        check("rst_busy",     busy,     1'b0);
        run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        trace.delete();
        start_idle = 1'b1;
        halted = 1'b0;
    endtask

    task automatic step(input logic [31:0] inst, input bit br, input int id,
                        input int dd, input bit run_end);
        model_instr(inst, br, id, dd, run_end);
        play(trace.size());
        if (halted) do_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] inst;
        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1111111};
        run = 0; imem_ack = 0; dmem_ack = 0; br_taken = 0;
        opcode = 0; fn3 = 0; fn7 = 0; rst_n = 1'b1;
        #2;
        do_reset();

        // Directed instructions
        step(32'h002081B3, 0, 0, 0, 1);   // add
        step(32'h402081B3, 0, 0, 0, 1);   // sub
        step(32'h0002A203, 0, 0, 3, 1);   // lw, dmem_ack after 3 wait cycles
        step(32'h00940063, 1, 0, 0, 1);   // beq taken
        step(32'h00940063, 0, 1, 0, 0);   // beq not taken, run dropped -> IDLE
        step(32'h0062A023, 0, 0, 1, 1);   // sw
        step(32'h008000EF, 0, 0, 0, 1);   // jal
        step(32'h000080E7, 0, 0, 0, 1);   // jalr
        step(32'h123450B7, 0, 0, 0, 1);   // lui
        step(32'h00001097, 0, 0, 0, 1);   // auipc
        step(32'h4010D093, 0, 0, 0, 1);   // srai: alu_op 1101
        step(32'h40108093, 0, 0, 0, 1);   // addi, imm bit 30 set: alu_op 0000

        // Timeout boundaries
        step(32'h002081B3, 0, 3, 0, 1);   // ack on the last allowed cycle
        step(32'h002081B3, 0, 4, 0, 1);   // no ack -> HALT, err
        step(32'h0002A203, 0, 0, 3, 1);
        step(32'h0002A203, 0, 0, 4, 1);   // data-side timeout

        // Illegal opcode
        step(32'h0000007F, 0, 0, 0, 1);
        step(32'h0000007F, 0, 0, 0, 0);

        // Reset asserted mid-MEM
        model_instr(32'h0002A203, 0, 0, 3, 1);
        while (trace.size() > 0 && trace[0].st != 3'd4) play(1);
        play(2);
        check("mem_pre_rst_dmem_req", dmem_req, 1'b1);
        do_reset();
        step(32'h002081B3, 0, 0, 0, 1);

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            inst = $urandom;
            inst[6:0] = ops[$urandom_range(0, 9)];
            step(inst, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
